opfetch_prefetch_queue: RTL and testbench
=========================================

Name: opfetch_prefetch_queue

Overview:
- Parametrised opcode/operand prefetch unit for the 65816 CPU controller; successor to the single-cycle opcode fetch decode step.
- Fetches program bytes ahead of the controller from {pbr, pc} into a DEPTH-entry FIFO.
- Tags each byte with its 24-bit fetch address. Supports flush on redirect and a WAI hold mode released by irq.
- Sits between the CPU controller (consumer) and the bus arbiter (memory port).

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
ADDR_W, 24, fetch address width; bank = ADDR_W-1:16, in-bank offset = 15:0
DATA_W, 8, bytes per entry (bus data width)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
redir  in  1  flush queue and restart fetch at redir_addr
redir_addr  in  ADDR_W  new fetch address {pbr, pc}
wait_req  in  1  WAI executed; enter HOLD
irq  in  1  pending interrupt; releases HOLD
mem_req  out  1  fetch request; held until mem_ack
mem_addr  out  ADDR_W  fetch address; stable while mem_req
mem_ack  in  1  request completed this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ack
q_valid  out  1  head entry valid
q_data  out  DATA_W  head byte
q_addr  out  ADDR_W  fetch address of head byte
q_pop  in  1  consumer takes head this cycle; ignored when q_valid=0
q_count  out  clog2(DEPTH)+1  stored entries
hold  out  1  block is in HOLD

Behaviour:
- Reset is asynchronous, active-low. Clock is clk.
- Outputs during and after reset: mem_req=0, mem_addr=0, q_valid=0, q_data=0, q_addr=0, q_count=0, hold=0. Internal state: IDLE, fetch pointer fptr=0, discard flag=0.
- States:
  - IDLE: no requests. redir -> FETCH.
  - FETCH: issue requests while q_count + outstanding < DEPTH.
  - HOLD: no new requests.
- At most one outstanding request. mem_req and mem_addr are registered. mem_addr=fptr while requesting.
- On mem_ack:
  - rdata is pushed with tag fptr.
  - fptr[15:0] increments modulo 2^16; the bank is unchanged, so FFFF wraps to 0000 in the same bank.
  - A new request may be asserted in the cycle after ack.
- Latency: ack in cycle N with an empty queue gives q_valid=1 in cycle N+1. q_data and q_addr are registered from the head.
- Push and pop in the same cycle: q_count unchanged, head advances. Full: no request is issued, so no overflow is possible. Pop when empty: ignored.
- redir (any state) takes priority over pop, push, wait_req and irq:
  - Queue is cleared (q_valid=0, q_count=0 next cycle), fptr=redir_addr, state=FETCH.
  - If a request is outstanding and not acked this cycle, discard=1. The next ack is dropped, discard clears, and the fetch at redir_addr then starts.
  - If ack coincides with redir, that data is dropped and discard is not set.
  - mem_req may drop only after the ack, never before.
- wait_req in FETCH with irq=0: enter HOLD next cycle, hold=1.
  - An outstanding request completes and is pushed, but q_valid is forced 0.
  - irq=1 -> FETCH next cycle; stored entries become visible.
- wait_req together with irq: no HOLD (pc not stalled).
- Reset mid-request: all state clears. A late mem_ack after reset is ignored in IDLE.

Optional Feature:
- Macro: OPFETCH_BYPASS_EN.
- Defined:
  - When the queue is empty, state is FETCH, discard=0 and redir=0, mem_ack forwards mem_rdata/fptr combinationally to q_data/q_addr with q_valid=1 in the same cycle.
  - If q_pop is also 1, the byte is consumed and not stored.
- Undefined: the registered one-cycle latency above always applies.

Test Plan:
- Reset, redir to 0x80_FFFE, ack every 2nd cycle, no pops -> mem_addr sequence 80FFFE, 80FFFF, 800000, 800001, then mem_req=0; q_count=4; q_addr head=80FFFE.
- Full queue, pop and ack back-to-back for 20 cycles -> q_data order matches rdata order, no loss or duplicate, q_count never exceeds 4.
- Request to 0x00_1000 outstanding, redir to 0x01_2000, ack 3 cycles later with data 0xAA -> 0xAA is never presented; next mem_addr=012000.
- redir and mem_ack in the same cycle -> acked byte dropped, discard stays 0; next request at redir_addr in the following cycle.
- wait_req with a request outstanding; ack 0x5C; irq after 10 cycles -> hold=1 and q_valid=0 throughout; no new mem_req; 0x5C visible the cycle after the irq-exit cycle.
- With OPFETCH_BYPASS_EN defined, queue empty, ack 0x42 with q_pop=1 -> q_valid=1, q_data=0x42 the same cycle; q_count stays 0.

Source files
------------

// File: rtl/opfetch_prefetch_queue.sv
// opfetch_prefetch_queue
//   Prefetches program bytes from {pbr, pc} ahead of the 65816 controller into
//   a DEPTH-entry FIFO. Each byte is tagged with its fetch address. A redirect
//   flushes the queue and restarts fetching. WAI parks the unit in HOLD until
//   irq arrives.
//
//   Optional feature macro: OPFETCH_BYPASS_EN. When it is defined, an ack that
//   lands on an empty queue is forwarded to the head outputs in the same cycle.
//
// Ports
//   clk, n_rst            clock, asynchronous active-low reset
//   redir, redir_addr     flush the queue and restart fetching at redir_addr
//   wait_req, irq         enter HOLD (WAI) / leave HOLD (interrupt)
//   mem_req, mem_addr     registered fetch request; held until mem_ack
//   mem_ack, mem_rdata    request completion and its read data
//   q_valid, q_data,      head entry valid, head byte, fetch address of head
//   q_addr
//   q_pop                 consumer takes the head this cycle
//   q_count               number of stored entries
//   hold                  unit is in HOLD
module opfetch_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   redir,
  input  logic [ADDR_W-1:0]      redir_addr,
  input  logic                   wait_req,
  input  logic                   irq,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   q_valid,
  output logic [DATA_W-1:0]      q_data,
  output logic [ADDR_W-1:0]      q_addr,
  input  logic                   q_pop,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   hold
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fptr_q, fptr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              discard_q, discard_d;
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]       cnt_q, cnt_d;

  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [ADDR_W-1:0] tag_q [DEPTH];

  logic head_vis, bypass, take, push, pop_fifo;

  always_comb begin
    head_vis = (cnt_q != '0) && (state_q != S_HOLD);
`ifdef OPFETCH_BYPASS_EN
    bypass = mem_req_q && mem_ack && (cnt_q == '0) && (state_q == S_FETCH) &&
             !discard_q && !redir;
`else
    bypass = 1'b0;
`endif
    q_valid = head_vis || bypass;
    if (bypass) begin
      q_data = mem_rdata;
      q_addr = fptr_q;
    end else if (head_vis) begin
      q_data = dat_q[rd_q];
      q_addr = tag_q[rd_q];
    end else begin
      q_data = '0;
      q_addr = '0;
    end

    // take: a live byte arrived and advances fptr; push: it is also stored
    // (a bypassed byte popped in the same cycle is consumed, not stored).
    take     = mem_req_q && mem_ack && !discard_q && !redir;
    push     = take && !(bypass && q_pop);
    pop_fifo = q_pop && head_vis && !redir;
  end

  always_comb begin
    state_d   = state_q;
    fptr_d    = fptr_q;
    discard_d = discard_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;

    if (redir) begin
      state_d   = S_FETCH;
      fptr_d    = redir_addr;
      rd_d      = '0;
      wr_d      = '0;
      cnt_d     = '0;
      // A request still in flight will return stale data; drop it on arrival.
      discard_d = mem_req_q && !mem_ack;
    end else begin
      if (discard_q && mem_req_q && mem_ack) discard_d = 1'b0;
      if (take) fptr_d = {fptr_q[ADDR_W-1:16], fptr_q[15:0] + 16'd1};
      if (push) wr_d = wr_q + PW'(1);
      if (pop_fifo) rd_d = rd_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop_fifo);
      unique case (state_q)
        S_FETCH: if (wait_req && !irq) state_d = S_HOLD;
        S_HOLD:  if (irq) state_d = S_FETCH;
        default: ;
      endcase
    end

    // Request is held until acked; otherwise decide from next-cycle occupancy.
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (!(mem_req_q && !mem_ack)) begin
      if ((state_d == S_FETCH) && !discard_d && (cnt_d < DEPTH_C)) begin
        mem_req_d  = 1'b1;
        mem_addr_d = fptr_d;
      end else begin
        mem_req_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      fptr_q     <= '0;
      discard_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fptr_q     <= fptr_d;
      discard_q  <= discard_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible when cnt_q says so.
  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wr_q] <= mem_rdata;
      tag_q[wr_q] <= fptr_q;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign q_count  = cnt_q;
  assign hold     = (state_q == S_HOLD);

endmodule

// File: tb/tb_opfetch_prefetch_queue.sv
module tb_opfetch_prefetch_queue;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        redir = 1'b0;
  logic [23:0] redir_addr = '0;
  logic        wait_req = 1'b0;
  logic        irq = 1'b0;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        q_valid;
  logic [7:0]  q_data;
  logic [23:0] q_addr;
  logic        q_pop = 1'b0;
  logic [2:0]  q_count;
  logic        hold;

  always #5 clk = ~clk;

  opfetch_prefetch_queue #(.DEPTH(4), .ADDR_W(24), .DATA_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .redir(redir), .redir_addr(redir_addr),
    .wait_req(wait_req), .irq(irq), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .q_valid(q_valid),
    .q_data(q_data), .q_addr(q_addr), .q_pop(q_pop), .q_count(q_count),
    .hold(hold)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2;
  typedef struct packed {logic [23:0] a; logic [7:0] d;} ent_t;
  ent_t        mq[$];
  int          m_state;
  logic [23:0] m_fptr, m_addr;
  bit          m_req, m_disc;

  task automatic model_reset();
    mq.delete();
    m_state = M_IDLE; m_fptr = '0; m_addr = '0; m_req = 0; m_disc = 0;
  endtask

  function automatic bit model_bypass();
    bit b = 0;
`ifdef OPFETCH_BYPASS_EN
    b = m_req && mem_ack && (mq.size() == 0) && (m_state == M_FETCH) && !m_disc && !redir;
`endif
    return b;
  endfunction

  task automatic model_update();
    bit vis, byp, got;
    ent_t e;
    vis = (mq.size() != 0) && (m_state != M_HOLD);
    byp = model_bypass();
    if (redir) begin
      mq.delete();
      if (m_req && !mem_ack) m_disc = 1;
      else begin m_disc = 0; m_req = 1; m_addr = redir_addr; end
      m_fptr  = redir_addr;
      m_state = M_FETCH;
    end else begin
      got = m_req && mem_ack;
      if (q_pop && vis) void'(mq.pop_front());
      if (got && m_disc) m_disc = 0;
      else if (got) begin
        if (!(byp && q_pop)) begin e.a = m_fptr; e.d = mem_rdata; mq.push_back(e); end
        m_fptr = {m_fptr[23:16], m_fptr[15:0] + 16'd1};
      end
      if (m_state == M_FETCH && wait_req && !irq) m_state = M_HOLD;
      else if (m_state == M_HOLD && irq) m_state = M_FETCH;
      if (!(m_req && !mem_ack)) begin
        if (m_state == M_FETCH && !m_disc && mq.size() < 4) begin m_req = 1; m_addr = m_fptr; end
        else m_req = 0;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic [23:0] alog[$];
  bit          log_en = 0, pop_chk = 0, saw_aa = 0;
  logic [7:0]  pop_exp = 8'h10;
  int          cnt_max = 0;

  task automatic compare();
    bit vis, byp;
    vis = (mq.size() != 0) && (m_state != M_HOLD);
    byp = model_bypass();
    check("mem_req", mem_req, m_req);
    if (m_req) check("mem_addr", mem_addr, m_addr);
    check("q_valid", q_valid, vis || byp);
    if (byp) begin
      check("q_data_byp", q_data, mem_rdata);
      check("q_addr_byp", q_addr, m_fptr);
    end else if (vis) begin
      check("q_data", q_data, mq[0].d);
      check("q_addr", q_addr, mq[0].a);
    end
    check("q_count", q_count, mq.size());
    check("hold", hold, m_state == M_HOLD);
    if (log_en && mem_req && mem_ack) alog.push_back(mem_addr);
    if (q_valid && q_data == 8'hAA) saw_aa = 1;
    if (int'(q_count) > cnt_max) cnt_max = int'(q_count);
    if (pop_chk && q_pop && q_valid) begin
      check("pop_order", q_data, pop_exp);
      pop_exp++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  bit         auto_mem = 0;
  int         ack_gap = 1, wcnt = 0;
  logic [7:0] data_ctr = 8'h10;

  task automatic step();
    bit was_req;
    if (auto_mem) begin
      mem_ack   = m_req && (wcnt >= ack_gap);
      mem_rdata = data_ctr;
    end
    #1 compare();
    @(posedge clk);
    was_req = m_req;
    model_update();
    if (auto_mem) begin
      if (mem_ack) begin data_ctr++; wcnt = 0; end
      else if (was_req) wcnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    model_reset();
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_q_valid", q_valid, 0);
    check("rst_q_data", q_data, 0);
    check("rst_q_addr", q_addr, 0);
    check("rst_q_count", q_count, 0);
    check("rst_hold", hold, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    do_reset();
    repeat (2) step();

    // 1: bank wrap, ack every 2nd cycle, no pops
    log_en = 1; auto_mem = 1; ack_gap = 1; wcnt = 0;
    redir = 1; redir_addr = 24'h80FFFE; step(); redir = 0;
    repeat (12) step();
    log_en = 0;
    check("t1_nreq", alog.size(), 4);
    if (alog.size() == 4) begin
      check("t1_a0", alog[0], 24'h80FFFE);
      check("t1_a1", alog[1], 24'h80FFFF);
      check("t1_a2", alog[2], 24'h800000);
      check("t1_a3", alog[3], 24'h800001);
    end
    check("t1_req_off", mem_req, 0);
    check("t1_count", q_count, 4);
    check("t1_head_addr", q_addr, 24'h80FFFE);
    check("t1_head_data", q_data, 8'h10);

    // 2: full queue, pop and ack back-to-back
    pop_chk = 1; q_pop = 1; ack_gap = 0; cnt_max = 0;
    repeat (20) step();
    q_pop = 0; pop_chk = 0;
    check("t2_popped", pop_exp >= 8'h1E, 1);
    repeat (8) step();
    check("t2_cnt_max_le4", cnt_max <= 4, 1);
    check("t2_full", q_count, 4);

    // 3: redirect with a request in flight; stale 0xAA must be dropped
    auto_mem = 0; mem_ack = 0; saw_aa = 0;
    redir = 1; redir_addr = 24'h001000; step(); redir = 0;
    step();
    redir = 1; redir_addr = 24'h012000; step(); redir = 0;
    step(); step();
    mem_ack = 1; mem_rdata = 8'hAA; step(); mem_ack = 0;
    check("t3_req", mem_req, 1);
    check("t3_addr", mem_addr, 24'h012000);
    mem_ack = 1; mem_rdata = 8'h33; step(); mem_ack = 0;
    check("t3_no_aa", saw_aa, 0);
    check("t3_head", q_data, 8'h33);
    check("t3_head_addr", q_addr, 24'h012000);

    // 4: redirect coinciding with an ack
    redir = 1; redir_addr = 24'h020000; mem_ack = 1; mem_rdata = 8'h77; step();
    redir = 0; mem_ack = 0;
    check("t4_req", mem_req, 1);
    check("t4_addr", mem_addr, 24'h020000);
    check("t4_count", q_count, 0);
    mem_ack = 1; mem_rdata = 8'h21; step(); mem_ack = 0;
    check("t4_kept", q_count, 1);
    check("t4_data", q_data, 8'h21);
    check("t4_taddr", q_addr, 24'h020000);

    // 5: WAI hold with a request outstanding, released by irq
    q_pop = 1; wait_req = 1; step(); q_pop = 0; wait_req = 0;
    check("t5_hold", hold, 1);
    mem_ack = 1; mem_rdata = 8'h5C; step(); mem_ack = 0;
    repeat (10) step();
    check("t5_hidden", q_valid, 0);
    check("t5_stored", q_count, 1);
    check("t5_noreq", mem_req, 0);
    irq = 1; step(); irq = 0;
    check("t5_vis", q_valid, 1);
    check("t5_data", q_data, 8'h5C);
    check("t5_addr", q_addr, 24'h020001);
    check("t5_exit", hold, 0);

    // 6: wait_req with irq does not hold
    wait_req = 1; irq = 1; step(); wait_req = 0; irq = 0;
    check("t6_nohold", hold, 0);
    step();

    // 7: reset with a request outstanding, then a late ack
    do_reset();
    mem_ack = 1; mem_rdata = 8'h99; step(); mem_ack = 0;
    step();
    check("t7_req", mem_req, 0);
    check("t7_count", q_count, 0);

    // 8: ack onto an empty queue with a simultaneous pop
    redir = 1; redir_addr = 24'h030000; step(); redir = 0;
    mem_ack = 1; mem_rdata = 8'h42; q_pop = 1;
    #1;
`ifdef OPFETCH_BYPASS_EN
    check("t8_byp_valid", q_valid, 1);
    check("t8_byp_data", q_data, 8'h42);
    check("t8_byp_addr", q_addr, 24'h030000);
`else
    check("t8_valid", q_valid, 0);
`endif
    step(); mem_ack = 0; q_pop = 0;
`ifdef OPFETCH_BYPASS_EN
    check("t8_count", q_count, 0);
`else
    check("t8_count", q_count, 1);
`endif
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
